// File: rtl/avl_burst_mem_slave_if.sv
// Avalon-MM burst bus between the cache m0 master and the burst memory responder.
interface avl_burst_mem_slave_if;
  logic [31:0] s0_address;
  logic [3:0]  s0_byteEnable;
  logic        s0_read;
  logic        s0_write;
  logic [31:0] s0_writeData;
  logic        s0_beginBurstTransfer;
  logic [7:0]  s0_burstCount;
  logic [31:0] s0_readData;
  logic        s0_readDataValid;
  logic        s0_waitRequest;

  modport master (
    output s0_address, s0_byteEnable, s0_read, s0_write, s0_writeData,
           s0_beginBurstTransfer, s0_burstCount,
    input  s0_readData, s0_readDataValid, s0_waitRequest
  );

  modport slave (
    input  s0_address, s0_byteEnable, s0_read, s0_write, s0_writeData,
           s0_beginBurstTransfer, s0_burstCount,
    output s0_readData, s0_readDataValid, s0_waitRequest
  );
endinterface

// File: rtl/avl_burst_mem_slave.sv
// Burst-capable word memory responder: single/burst reads and writes, programmable
// read latency, optional LFSR-driven wait states. One read burst outstanding at a time.
module avl_burst_mem_slave #(
  parameter int unsigned DEPTH_WORDS  = 8192,
  parameter int unsigned READ_LATENCY = 2,
  parameter bit          STALL_EN     = 1'b0,
  parameter logic [15:0] STALL_SEED   = 16'hACE1
) (
  input logic clk,
  input logic rest,
  avl_burst_mem_slave_if.slave s0
);
  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [2:0]  LAT_INIT = 3'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_WAIT, RD_BURST} state_e;

  state_e        state_q;
  logic [AW-1:0] ptr_q;
  logic [7:0]    rem_q;
  logic [2:0]    lat_q;
  logic [15:0]   lfsr_q;
  logic [31:0]   rdata_q;
  logic          rvalid_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          stall;
  logic          wait_req;
  logic          wr_acc;
  logic          rd_acc;
  logic [AW-1:0] addr_w;
  logic [AW-1:0] waddr;
  logic [7:0]    beats;
  logic          unused_bits;

  assign addr_w = s0.s0_address[AW+1:2];
  assign beats  = (s0.s0_burstCount == 8'd0) ? 8'd1 : s0.s0_burstCount;
  assign stall  = STALL_EN && (lfsr_q[1:0] == 2'b00);

  always_comb begin
    wait_req = 1'b1;
    if (!rest && (state_q == IDLE || state_q == WR_BURST)) wait_req = stall;
  end

  // wait_req is forced high in the read states, so writes can only land in IDLE/WR_BURST
  assign wr_acc = s0.s0_write && !wait_req;
  assign rd_acc = s0.s0_read && !s0.s0_write && !wait_req && (state_q == IDLE);
  assign waddr  = (state_q == IDLE) ? addr_w : ptr_q;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (s0.s0_byteEnable[i]) mem[waddr][8*i +: 8] <= s0.s0_writeData[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      rem_q    <= '0;
      lat_q    <= '0;
      lfsr_q   <= STALL_SEED;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      lfsr_q   <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      rvalid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (wr_acc) begin
            ptr_q <= addr_w + 1'b1;
            if (beats > 8'd1) begin
              rem_q   <= beats - 8'd1;
              state_q <= WR_BURST;
            end
          end else if (rd_acc) begin
            // Unit latency: first beat is presented straight off the acceptance edge
            if (READ_LATENCY <= 1) begin
              rdata_q  <= mem[addr_w];
              rvalid_q <= 1'b1;
              ptr_q    <= addr_w + 1'b1;
              rem_q    <= beats - 8'd1;
              state_q  <= RD_BURST;
            end else begin
              ptr_q   <= addr_w;
              rem_q   <= beats;
              lat_q   <= LAT_INIT;
              state_q <= RD_WAIT;
            end
          end
        end
        WR_BURST: begin
          if (wr_acc) begin
            ptr_q <= ptr_q + 1'b1;
            rem_q <= rem_q - 8'd1;
            if (rem_q == 8'd1) state_q <= IDLE;
          end
        end
        RD_WAIT: begin
          if (lat_q == 3'd0) begin
            rdata_q  <= mem[ptr_q];
            rvalid_q <= 1'b1;
            ptr_q    <= ptr_q + 1'b1;
            rem_q    <= rem_q - 8'd1;
            state_q  <= RD_BURST;
          end else begin
            lat_q <= lat_q - 3'd1;
          end
        end
        RD_BURST: begin
          // rem_q counts beats still to present after the one on the bus now
          if (rem_q == 8'd0) begin
            state_q <= IDLE;
          end else begin
            rdata_q  <= mem[ptr_q];
            rvalid_q <= 1'b1;
            ptr_q    <= ptr_q + 1'b1;
            rem_q    <= rem_q - 8'd1;
          end
        end
      endcase
    end
  end

  assign s0.s0_readData      = rdata_q;
  assign s0.s0_readDataValid = rvalid_q;
  assign s0.s0_waitRequest   = wait_req;

  assign unused_bits = ^{s0.s0_address[31:AW+2], s0.s0_address[1:0], s0.s0_beginBurstTransfer};
endmodule

// File: doc/avl_burst_mem_slave.md
# avl_burst_mem_slave

Synthesizable burst-capable memory responder for the cache's `m0` master port: accepts Avalon-style single and burst reads/writes (`beginBurstTransfer`/`burstCount`), stores data in an internal word array, and returns read bursts after a programmable latency. It replaces the zero-wait, non-burst SDRAM model behind the cache in unit and FPGA-level benches. It also exercises the cache's burst refill/write-back paths with optional pseudo-random wait states.

## Interface
- `DEPTH_WORDS`, 8192: memory depth in 32-bit words (power of two); `AW = $clog2(DEPTH_WORDS)`.
- `READ_LATENCY`, 2: cycles from read acceptance edge to first `readDataValid` (legal range 1..8).
- `STALL_EN`, 0: 1 enables LFSR-driven wait states.
- `STALL_SEED`, 16'hACE1: LFSR reset value (must be nonzero).

- `clk` in 1: clock, all logic on rising edge.
- `rest` in 1: reset, asynchronous, active-high.
- `s0_address` in 32: byte address; word index `s0_address[AW+1:2]`, upper bits ignored (wraps).
- `s0_byteEnable` in 4: per-byte write enables; ignored for reads.
- `s0_read` in 1: read request.
- `s0_write` in 1: write request/beat.
- `s0_writeData` in 32: write beat data.
- `s0_beginBurstTransfer` in 1: marks first cycle of a burst (informational; command start is decided by state).
- `s0_burstCount` in 8: beats in burst, sampled on first accepted beat; 0 treated as 1.
- `s0_readData` out 32: read beat data.
- `s0_readDataValid` out 1: `s0_readData` valid this cycle.
- `s0_waitRequest` out 1: command/beat not accepted this cycle.

## Operation
- States: IDLE, WR_BURST, RD_WAIT, RD_BURST.
- Accept = (`s0_read` | `s0_write`) & !`s0_waitRequest`.
- `stall` = `STALL_EN` & (`lfsr[1:0]==0`); LFSR 16-bit Fibonacci, taps 16,14,13,11, advances every cycle, loads `STALL_SEED` on reset.
- `s0_waitRequest`: 1 while `rest`; IDLE/WR_BURST → `stall`; RD_WAIT/RD_BURST → 1 (one outstanding read burst, no pipelining).
- IDLE, write accepted: write beat 0 at word `A = s0_address[AW+1:2]`; latch `beats = max(burstCount,1)`, `ptr = A+1`; if beats==1 stay IDLE else → WR_BURST.
- WR_BURST: each accepted `s0_write` writes beat at `ptr` (master's address ignored), `ptr++`, remaining--; last beat → IDLE. `s0_read` in WR_BURST ignored (never accepted).
- IDLE, read accepted (and `s0_write`=0): latch `ptr=A`, `beats`, latency counter; → RD_WAIT (READ_LATENCY>1) or RD_BURST (READ_LATENCY==1).
- RD_BURST: one beat per cycle, back-to-back, `s0_readData = mem[ptr]`, `ptr++`; last beat → IDLE.
- Both `s0_read` and `s0_write` high in IDLE: write wins, read dropped.
- Byte writes: only bytes with `byteEnable[i]=1` change; enable 0000 consumes a beat, no change.
- `ptr` arithmetic is AW bits, wraps modulo `DEPTH_WORDS`.
- Memory contents are not cleared by `rest`; initialized to zero at time 0 (simulation init / FPGA init file).

## Timing
- Reset outputs: `s0_readDataValid=0`, `s0_readData=0`, `s0_waitRequest=1`, state IDLE, counters 0; asserting `rest` mid-burst aborts immediately, no further beats; already written beats remain.
- Read accepted at edge k: first `readDataValid` in the cycle following edge k+READ_LATENCY−1 (READ_LATENCY=1 → cycle right after acceptance); beat n follows n cycles later.
- `s0_waitRequest` stays 1 through the cycle carrying the last valid beat; IDLE (and acceptance possible) from the next cycle.
- Write beat accepted at edge k is visible to any read accepted at edge ≥ k+1.
- `s0_readData` holds last beat value when `readDataValid`=0.

## Test plan
- Single read after reset, STALL_EN=0, READ_LATENCY=1: read 0x40 → waitRequest=0, readDataValid one cycle later, data 0x00000000.
- Write burst 4 @0x100, data 0x11111111..0x44444444, byteEnable 1111, then read burst 4 @0x100, READ_LATENCY=3 → 4 consecutive valid beats exactly matching, first valid 3 cycles after accept, waitRequest=1 throughout.
- Byte enables: write 0xAABBCCDD be=1111 @0x200, then 0x11223344 be=0101 → read returns 0xAA22CC44.
- Wrap/burstCount: DEPTH_WORDS=8192, write burst 2 @0x7FFC data 1,2 then single read @0x0 → 2; burstCount=0 read → exactly one beat.
- STALL_EN=1: 1000 random reads/writes with random bursts 1..16 vs shadow model → zero mismatches, no beat accepted while waitRequest=1.
- Assert `rest` during beat 3 of an 8-beat read → readDataValid=0 same cycle, waitRequest=1; after release new read accepted normally.
